// File: rtl/ray_column_scheduler_if.sv
// Raycaster request/result channel between the column scheduler (master)
// and the per-column raycaster (slave).
//
// Handshake: the master pulses ray_start for exactly one cycle and holds
// ray_col stable from that cycle until the column is resolved. The slave
// answers with a single-cycle ray_valid carrying ray_data/ray_bright for
// that ray_col. There is no ready signal: the master is always waiting
// while a column is outstanding, and a ray_valid that arrives while no
// column is outstanding is dropped. If no answer arrives within the
// master's timeout, the master resolves the column on its own and moves on.
interface ray_column_scheduler_if #(
    parameter int COL_W    = 10,
    parameter int DATA_W   = 12,
    parameter int BRIGHT_W = 16
);
    logic                ray_start;
    logic [COL_W-1:0]    ray_col;
    logic                ray_valid;
    logic [DATA_W-1:0]   ray_data;
    logic [BRIGHT_W-1:0] ray_bright;

    modport master (
        output ray_start,
        output ray_col,
        input  ray_valid,
        input  ray_data,
        input  ray_bright
    );

    modport slave (
        input  ray_start,
        input  ray_col,
        output ray_valid,
        output ray_data,
        output ray_bright
    );
endinterface

// File: rtl/ray_column_scheduler.sv
// Per-column raycast sequencer with a double-buffered column store.
// Each frame it casts columns 0..NUM_COLS-1 one at a time into the back
// half of a two-frame RAM; at the next vsync falling edge a complete back
// half becomes the front half that the display reads by DrawX. An
// incomplete frame is discarded at the edge so the display never shows a
// mix of two frames.
module ray_column_scheduler #(
    parameter int NUM_COLS = 640,
    parameter int COL_W    = 10,
    parameter int DATA_W   = 12,
    parameter int BRIGHT_W = 16,
    parameter int TIMEOUT  = 1023
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                vsync,
    input  logic [COL_W-1:0]    DrawX,
    ray_column_scheduler_if.master rc,
    output logic [DATA_W-1:0]   memdata,
    output logic [BRIGHT_W-1:0] brightness,
    output logic                frame_done,
    output logic                overrun,
    output logic [7:0]          timeouts,
    output logic [1:0]          dbg_state
);

    // One RAM word holds a whole column result.
    localparam int WORD_W = DATA_W + BRIGHT_W;
    // Two frames of columns: lower half is buffer 0, upper half buffer 1.
    localparam int DEPTH  = 2 * NUM_COLS;
    localparam int AW     = $clog2(DEPTH);
    // Wait counter only needs to reach TIMEOUT-1.
    localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(NUM_COLS - 1);
    localparam logic [TW-1:0]    WAIT_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW-1:0]    HALF_OFS  = AW'(NUM_COLS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [COL_W-1:0]  col, col_n;
    logic [TW-1:0]     wait_cnt, wait_cnt_n;
    logic              front_sel, front_sel_n;
    logic              vsync_q;
    logic              frame_done_n;
    logic              overrun_n;
    logic [7:0]        timeouts_n;
    logic              fe;

    // Write port (back buffer) and read port (front buffer).
    logic              we;
    logic [WORD_W-1:0] wdata;
    logic [AW-1:0]     waddr;
    logic [AW-1:0]     raddr;
    logic              rd_hit;
    logic              rd_ok;
    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] mem [DEPTH];

    // Frame boundary: vsync is active-low, so the falling edge opens a frame.
    assign fe = vsync_q & ~vsync;

    assign rc.ray_start = (state == S_ISSUE);
    assign rc.ray_col   = col;
    assign dbg_state    = state;

    // The back buffer is always the half the display is not reading.
    assign waddr  = front_sel ? AW'(col) : (HALF_OFS + AW'(col));
    assign raddr  = front_sel ? (HALF_OFS + AW'(DrawX)) : AW'(DrawX);
    assign rd_hit = (32'(DrawX) < 32'(NUM_COLS));

    // Next-state logic: column walk, result capture, timeout fallback and
    // frame-edge handling (an edge always restarts the walk at column 0).
    always_comb begin
        state_n      = state;
        col_n        = col;
        wait_cnt_n   = wait_cnt;
        front_sel_n  = front_sel;
        frame_done_n = frame_done;
        overrun_n    = overrun;
        timeouts_n   = timeouts;
        we           = 1'b0;
        wdata        = '0;

        case (state)
            S_IDLE: begin
                if (fe) begin
                    col_n   = '0;
                    state_n = S_ISSUE;
                end
            end

            S_ISSUE: begin
                wait_cnt_n = '0;
                if (fe) begin
                    // Frame ended before this one was complete: drop it.
                    overrun_n = 1'b1;
                    col_n     = '0;
                    state_n   = S_ISSUE;
                end else begin
                    state_n = S_WAIT;
                end
            end

            S_WAIT: begin
                if (fe) begin
                    // The edge wins over a simultaneous result; the partial
                    // frame is abandoned and the front buffer is untouched.
                    overrun_n = 1'b1;
                    col_n     = '0;
                    state_n   = S_ISSUE;
                end else if (rc.ray_valid || (wait_cnt == WAIT_LAST)) begin
                    we = 1'b1;
                    if (rc.ray_valid) begin
                        wdata = {rc.ray_data, rc.ray_bright};
                    end else begin
                        // Fallback: an empty column is better than a stall.
                        wdata = '0;
                        if (timeouts != 8'hFF) begin
                            timeouts_n = timeouts + 8'd1;
                        end
                    end
                    if (col == LAST_COL) begin
                        frame_done_n = 1'b1;
                        state_n      = S_DONE;
                    end else begin
                        col_n   = col + 1'b1;
                        state_n = S_ISSUE;
                    end
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end

            S_DONE: begin
                if (fe) begin
                    // Back buffer is complete: publish it and start anew.
                    front_sel_n  = ~front_sel;
                    frame_done_n = 1'b0;
                    col_n        = '0;
                    state_n      = S_ISSUE;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Control state and status registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_IDLE;
            col        <= '0;
            wait_cnt   <= '0;
            front_sel  <= 1'b0;
            vsync_q    <= 1'b1;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            timeouts   <= '0;
        end else begin
            state      <= state_n;
            col        <= col_n;
            wait_cnt   <= wait_cnt_n;
            front_sel  <= front_sel_n;
            vsync_q    <= vsync;
            frame_done <= frame_done_n;
            overrun    <= overrun_n;
            timeouts   <= timeouts_n;
        end
    end

    // Column store write port; contents are deliberately not reset.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Column store synchronous read port for the display.
    always_ff @(posedge Clk) begin
        if (rd_hit) begin
            rd_word <= mem[raddr];
        end
    end

    // Tracks whether the registered read word belongs to an in-range DrawX.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_ok <= 1'b0;
        end else begin
            rd_ok <= rd_hit;
        end
    end

    assign memdata    = rd_ok ? rd_word[WORD_W-1:BRIGHT_W] : '0;
    assign brightness = rd_ok ? rd_word[BRIGHT_W-1:0]      : '0;

endmodule

// File: tb/tb_ray_column_scheduler.sv
// Directed-sequence bench for ray_column_scheduler with a randomized
// raycaster responder. The reference model is a pair of per-column arrays:
// back_exp collects what the responder delivered in the current frame
// (zero for unanswered columns) and front_exp is what the display must show.
module tb_ray_column_scheduler;

    localparam int NC = 8;
    localparam int CW = 4;
    localparam int DW = 12;
    localparam int BW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vsync = 1'b1;
    logic [CW-1:0] draw_x = '0;
    logic [DW-1:0] memdata;
    logic [BW-1:0] brightness;
    logic          frame_done;
    logic          overrun;
    logic [7:0]    timeouts;
    logic [1:0]    dbg_state;

    ray_column_scheduler_if #(.COL_W(CW), .DATA_W(DW), .BRIGHT_W(BW)) rif();

    ray_column_scheduler #(
        .NUM_COLS(NC), .COL_W(CW), .DATA_W(DW), .BRIGHT_W(BW), .TIMEOUT(TO)
    ) dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .vsync     (vsync),
        .DrawX     (draw_x),
        .rc        (rif.master),
        .memdata   (memdata),
        .brightness(brightness),
        .frame_done(frame_done),
        .overrun   (overrun),
        .timeouts  (timeouts),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- stimulus state and model ----------------
    logic          r_valid, m_valid;
    logic [DW-1:0] r_data,  m_data;
    logic [BW-1:0] r_bright, m_bright;

    assign rif.ray_valid  = r_valid | m_valid;
    assign rif.ray_data   = m_valid ? m_data   : r_data;
    assign rif.ray_bright = m_valid ? m_bright : r_bright;

    logic [DW-1:0]    tab_d [NC];
    logic [BW-1:0]    tab_b [NC];
    logic [DW+BW-1:0] back_exp  [NC];
    logic [DW+BW-1:0] front_exp [NC];
    bit               resp_en  = 1'b0;
    bit               rnd_mode = 1'b0;
    int               drop_col = -1;
    int               start_cnt = 0;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- raycaster responder ----------------
    initial begin
        int cnt;
        int pc;
        cnt = 0;
        pc  = 0;
        r_valid = 1'b0;
        r_data  = '0;
        r_bright = '0;
        forever begin
            @(negedge clk);
            r_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    r_valid = 1'b1;
                    if (rnd_mode) begin
                        r_data   = tab_d[pc];
                        r_bright = tab_b[pc];
                    end else begin
                        r_data   = DW'(pc + 1);
                        r_bright = BW'(pc * 32'h1000);
                    end
                    back_exp[pc] = {r_data, r_bright};
                end
            end
            if (rif.ray_start) begin
                start_cnt++;
                pc = int'(rif.ray_col);
                if (resp_en && pc != drop_col && pc < NC)
                    cnt = rnd_mode ? int'($urandom_range(1, 4)) : 3;
                else
                    cnt = 0;
            end
        end
    end

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; produces one sampled falling edge of vsync.
    task automatic frame_edge();
        vsync = 1'b0;
        @(negedge clk);
        vsync = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && frame_done !== 1'b1; i++) @(negedge clk);
        check("frame_done", 32'(frame_done), 32'd1);
    endtask

    task automatic read_chk(input int c, input logic [DW+BW-1:0] e);
        draw_x = CW'(c);
        @(negedge clk);
        check($sformatf("memdata[%0d]", c), 32'(memdata), 32'(e[DW+BW-1:BW]));
        check($sformatf("brightness[%0d]", c), 32'(brightness), 32'(e[BW-1:0]));
    endtask

    task automatic new_table();
        for (int c = 0; c < NC; c++) begin
            tab_d[c]    = DW'($urandom);
            tab_b[c]    = BW'($urandom);
            back_exp[c] = '0;
        end
    endtask

    task automatic publish();
        for (int c = 0; c < NC; c++) front_exp[c] = back_exp[c];
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int s;
        int found;
        int gap;
        int exp_to;
        m_valid = 1'b0;
        m_data  = '0;
        m_bright = '0;
        for (int c = 0; c < NC; c++) begin
            back_exp[c]  = '0;
            front_exp[c] = '0;
        end

        // Reset held while vsync toggles: nothing may start.
        repeat (3) begin
            @(negedge clk); vsync = 1'b0;
            @(negedge clk); vsync = 1'b1;
        end
        check("rst_ray_start",  32'(rif.ray_start), 32'd0);
        check("rst_ray_col",    32'(rif.ray_col),   32'd0);
        check("rst_memdata",    32'(memdata),       32'd0);
        check("rst_brightness", 32'(brightness),    32'd0);
        check("rst_frame_done", 32'(frame_done),    32'd0);
        check("rst_overrun",    32'(overrun),       32'd0);
        check("rst_timeouts",   32'(timeouts),      32'd0);

        rst_n = 1'b1;
        tick(3);
        check("idle_no_start", 32'(rif.ray_start), 32'd0);

        // Frame 1: data = col+1, brightness = 0x1000*col, 3-cycle latency.
        resp_en = 1'b1;
        start_cnt = 0;
        frame_edge();
        check("f1_start", 32'(rif.ray_start), 32'd1);
        check("f1_col0",  32'(rif.ray_col),   32'd0);
        wait_done(100);
        check("f1_starts", 32'(start_cnt), 32'd8);
        s = 0;
        repeat (10) begin @(negedge clk); s += int'(rif.ray_start); end
        check("done_quiet", 32'(s), 32'd0);
        check("f1_overrun", 32'(overrun), 32'd0);
        for (int c = 0; c < NC; c++) front_exp[c] = {DW'(c + 1), BW'(c * 32'h1000)};

        // Frame 2: swap, random data; frame edge while casting column 3.
        new_table();
        rnd_mode = 1'b1;
        frame_edge();
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (rif.ray_col == CW'(3) && !rif.ray_start) begin found = 1; break; end
            @(negedge clk);
        end
        check("reach_col3_wait", 32'(found), 32'd1);
        frame_edge();
        check("ovr_flag",  32'(overrun),       32'd1);
        check("ovr_start", 32'(rif.ray_start), 32'd1);
        check("ovr_col",   32'(rif.ray_col),   32'd0);
        read_chk(5, {DW'(6), BW'(16'h5000)});
        for (int c = 0; c < NC; c++) read_chk(c, front_exp[c]);
        wait_done(100);
        check("ovr_sticky", 32'(overrun),  32'd1);
        check("f2_timeouts", 32'(timeouts), 32'd0);

        // Frame 3: publish frame 2, column 2 never answered.
        publish();
        new_table();
        drop_col = 2;
        frame_edge();
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (rif.ray_start && rif.ray_col == CW'(2)) begin found = 1; break; end
            @(negedge clk);
        end
        check("reach_col2_issue", 32'(found), 32'd1);
        gap = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            gap++;
            if (rif.ray_start && rif.ray_col == CW'(3)) break;
        end
        check("timeout_gap", 32'(gap), 32'(TO + 1));
        check("timeouts_1",  32'(timeouts), 32'd1);
        for (int c = 0; c < NC; c++) read_chk(c, front_exp[c]);
        wait_done(100);
        drop_col = -1;

        // Frame 4: publish frame 3 (column 2 zero), full random frame.
        publish();
        new_table();
        frame_edge();
        for (int c = 0; c < NC; c++) read_chk(c, front_exp[c]);
        wait_done(100);
        resp_en = 1'b0;

        // A result arriving while holding a finished frame must be dropped.
        m_data = 12'hABC; m_bright = 16'hDEAD; m_valid = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
        check("done_hold", 32'(frame_done), 32'd1);
        tick(2);

        // Frame 5: publish frame 4; result coincident with a frame edge.
        publish();
        for (int c = 0; c < NC; c++) back_exp[c] = '0;
        frame_edge();
        @(negedge clk);
        vsync = 1'b0; m_valid = 1'b1; m_data = 12'h5A5; m_bright = 16'h1234;
        @(negedge clk);
        vsync = 1'b1; m_valid = 1'b0;
        check("coinc_start", 32'(rif.ray_start), 32'd1);
        check("coinc_col",   32'(rif.ray_col),   32'd0);
        for (int c = 0; c < NC; c++) read_chk(c, front_exp[c]);
        read_chk(NC, '0);
        read_chk(NC + 1, '0);
        read_chk(3, front_exp[3]);
        wait_done(200);
        exp_to = 1 + NC;
        check("timeouts_frame5", 32'(timeouts), 32'(exp_to));

        // Frame 6: publish all-zero frame 5, then run timeouts to saturation.
        publish();
        frame_edge();
        read_chk(0, front_exp[0]);
        read_chk(5, front_exp[5]);
        wait_done(200);
        exp_to = exp_to + NC;
        repeat (30) begin
            frame_edge();
            wait_done(200);
            exp_to = (exp_to + NC > 255) ? 255 : exp_to + NC;
        end
        check("timeouts_sat", 32'(timeouts), 32'(exp_to));

        // Asynchronous reset while waiting on column 1.
        frame_edge();
        tick(6);
        check("pre_reset_col", 32'(rif.ray_col), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_ray_start",  32'(rif.ray_start), 32'd0);
        check("arst_ray_col",    32'(rif.ray_col),   32'd0);
        check("arst_frame_done", 32'(frame_done),    32'd0);
        check("arst_overrun",    32'(overrun),       32'd0);
        check("arst_timeouts",   32'(timeouts),      32'd0);
        check("arst_memdata",    32'(memdata),       32'd0);
        check("arst_brightness", 32'(brightness),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        check("post_reset_idle", 32'(rif.ray_start), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
